// File: rtl/gray_vector_checker.sv
// rtl/gray_vector_checker.sv - exhaustive Gray-order test engine for an N-input combinational function
//
// Purpose:
//   Walks every N-bit input vector in reflected-binary Gray order and holds each
//   one for DWELL cycles. On the last cycle of each hold it compares the
//   function's output against the EXPECT truth table. At the end of the run it
//   reports pass/fail, an error count and the first failing vector.
//
// Parameters:
//   N      - number of function inputs (1..8)
//   DWELL  - cycles each vector is held before sampling (>= 1)
//   EXPECT - truth table; EXPECT[v] is the required output for input vector v
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   begin a run (honoured only in IDLE or DONE)
//   dut_z           in   output of the function under test
//   dut_in          out  registered input vector driven to the function
//   busy            out  run in progress
//   done            out  run finished, held until next start or reset
//   pass            out  valid while done: no mismatches were seen
//   err_count       out  number of mismatching vectors (N+1 bits, no wrap)
//   first_err_valid out  at least one mismatch recorded this run
//   first_err_vec   out  dut_in value of the first mismatch, 0 if none

module gray_vector_checker #(
  parameter int              N      = 4,
  parameter int              DWELL  = 20,
  parameter logic [2**N-1:0] EXPECT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dut_z,
  output logic [N-1:0] dut_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         first_err_valid,
  output logic [N-1:0] first_err_vec
);

  // Dwell counter only has to reach DWELL-1; keep at least one bit so DWELL=1 still elaborates.
  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  k;        // binary index of the vector currently applied
  logic [CW-1:0] cnt;      // cycles already spent on the current vector

  logic          mismatch;
  logic [N:0]    err_next;
  logic [N-1:0]  k_next;
  logic [N-1:0]  gray_next;
  logic          last_vec;
  logic          sample;

  always_comb begin
    mismatch  = dut_z ^ EXPECT[dut_in];
    err_next  = err_count + {{N{1'b0}}, mismatch};
    k_next    = k + N'(1);
    // Reflected binary Gray code of the next index.
    gray_next = k_next ^ (k_next >> 1);
    last_vec  = (k == {N{1'b1}});
    sample    = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      k               <= '0;
      cnt             <= '0;
      dut_in          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE restarts exactly like IDLE, so results from the previous
          // run are cleared on the same edge that accepts start.
          if (start) begin
            state           <= S_RUN;
            k               <= '0;
            cnt             <= '0;
            dut_in          <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end

        S_RUN: begin
          if (!sample) begin
            cnt <= cnt + CW'(1);
          end else begin
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= dut_in;
            end
            if (last_vec) begin
              // dut_in intentionally left on the final code.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              k      <= k_next;
              dut_in <= gray_next;
              cnt    <= '0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_vector_checker.sv
// tb/tb_gray_vector_checker.sv - self-checking bench for gray_vector_checker

module tb_gray_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=4, DWELL=20, parity truth table
  logic        start;
  logic        dut_z;
  logic [3:0]  dut_in;
  logic        busy, done, pass;
  logic [4:0]  err_count;
  logic        first_err_valid;
  logic [3:0]  first_err_vec;
  logic [15:0] flip;   // vectors where the bench function is inverted

  // N=2, DWELL=1, AND truth table
  logic        start2;
  logic        dut_z2;
  logic [1:0]  dut_in2;
  logic        busy2, done2, pass2;
  logic [2:0]  err_count2;
  logic        first_err_valid2;
  logic [1:0]  first_err_vec2;
  logic [3:0]  flip2;

  always_comb dut_z  = (^dut_in) ^ flip[dut_in];
  always_comb dut_z2 = (&dut_in2) ^ flip2[dut_in2];

  gray_vector_checker #(.N(4), .DWELL(20), .EXPECT(16'h6996)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_z(dut_z), .dut_in(dut_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  gray_vector_checker #(.N(2), .DWELL(1), .EXPECT(4'b1000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_z(dut_z2), .dut_in(dut_in2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_valid(first_err_valid2), .first_err_vec(first_err_vec2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [3:0] gray_of(input int idx);
    return 4'(idx ^ (idx >> 1));
  endfunction

  // Reference: results after the first s vectors of the Gray walk were sampled.
  task automatic model(input logic [15:0] f, input int s,
                       output int e, output logic fv, output logic [3:0] fvec);
    logic [3:0] v;
    e = 0; fv = 1'b0; fvec = 4'd0;
    for (int i = 0; i < s; i++) begin
      v = gray_of(i);
      if (f[v]) begin
        e++;
        if (!fv) begin
          fv = 1'b1;
          fvec = v;
        end
      end
    end
  endtask

  // Full 16-vector run, checked every cycle; optional stray start at cycle ignore_at.
  task automatic run16(input logic [15:0] f, input int ignore_at, input string name);
    int e; logic fv; logic [3:0] fvec;
    logic [3:0] exp_in;
    flip = f;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j <= 320; j++) begin
      if (j > 0) begin
        @(posedge clk); #1 start = (j == ignore_at);
      end
      @(negedge clk);
      model(f, j / 20, e, fv, fvec);
      exp_in = (j < 320) ? gray_of(j / 20) : 4'b1000;
      n_cmp++;
      if (dut_in !== exp_in) begin
        n_bad++; $display("FAIL %s dut_in j=%0d got %h want %h", name, j, dut_in, exp_in);
      end
      n_cmp++;
      if (busy !== (j < 320)) begin
        n_bad++; $display("FAIL %s busy j=%0d got %b want %b", name, j, busy, j < 320);
      end
      n_cmp++;
      if (done !== (j == 320)) begin
        n_bad++; $display("FAIL %s done j=%0d got %b want %b", name, j, done, j == 320);
      end
      n_cmp++;
      if (err_count !== 5'(e)) begin
        n_bad++; $display("FAIL %s err_count j=%0d got %0d want %0d", name, j, err_count, e);
      end
      n_cmp++;
      if (first_err_valid !== fv || first_err_vec !== fvec) begin
        n_bad++; $display("FAIL %s first_err j=%0d got %b/%h want %b/%h",
                          name, j, first_err_valid, first_err_vec, fv, fvec);
      end
      if (j == 320 || j == 0) begin
        n_cmp++;
        if (pass !== (j == 320 && e == 0)) begin
          n_bad++; $display("FAIL %s pass j=%0d got %b want %b", name, j, pass, (j == 320 && e == 0));
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; flip = '0; flip2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec} !== '0) begin
      n_bad++; $display("FAIL reset4 got in=%h b=%b d=%b p=%b e=%0d fv=%b fe=%h want all 0",
                        dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec);
    end
    n_cmp++;
    if ({dut_in2, busy2, done2, pass2, err_count2, first_err_valid2, first_err_vec2} !== '0) begin
      n_bad++; $display("FAIL reset2 got in=%h b=%b d=%b p=%b e=%0d want all 0",
                        dut_in2, busy2, done2, pass2, err_count2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_pass_run();
    run16(16'h0000, -1, "pass_run");
  endtask

  task automatic test_two_faults();
    // Inverted at 0101 and 1100; 0101 is visited first.
    run16(16'h1020, -1, "two_faults");
  endtask

  task automatic test_all_fail();
    // Every vector disagrees with the table: count must reach 16 without wrapping.
    run16(16'hFFFF, -1, "all_fail");
  endtask

  task automatic test_start_ignored_and_restart();
    run16(16'h0000, 3 * 20 + 7, "start_in_run");
    run16(16'(($urandom & 32'hFFFF)), -1, "restart_from_done");
  endtask

  task automatic test_reset_midrun();
    flip = 16'hFFFF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6 * 20 + 5) @(posedge clk);
    n_cmp++;
    if (err_count !== 5'd6 || dut_in !== 4'b0101) begin
      n_bad++; $display("FAIL midrun_pre got err=%0d in=%h want 6/5", err_count, dut_in);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec} !== '0) begin
      n_bad++; $display("FAIL midrun_reset got in=%h b=%b d=%b e=%0d fv=%b fe=%h want all 0",
                        dut_in, busy, done, err_count, first_err_valid, first_err_vec);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL midrun_idle got b=%b d=%b want 0/0", busy, done);
    end
    run16(16'h0000, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run16(16'(($urandom & 32'hFFFF)), int'($urandom_range(1, 318)), "random");
    end
  endtask

  task automatic test_n2();
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      int e; logic fv; logic [1:0] fvec; logic [1:0] v; logic [1:0] exp_in;
      flip2 = (pass_no == 0) ? 4'b0000 : 4'b1000;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int j = 0; j <= 4; j++) begin
        if (j > 0) @(posedge clk);
        @(negedge clk);
        e = 0; fv = 1'b0; fvec = 2'd0;
        for (int i = 0; i < j; i++) begin
          v = 2'(i ^ (i >> 1));
          if (flip2[v]) begin
            e++;
            if (!fv) begin fv = 1'b1; fvec = v; end
          end
        end
        exp_in = (j < 4) ? 2'(j ^ (j >> 1)) : 2'b10;
        n_cmp++;
        if (dut_in2 !== exp_in) begin
          n_bad++; $display("FAIL n2 dut_in j=%0d got %b want %b", j, dut_in2, exp_in);
        end
        n_cmp++;
        if (busy2 !== (j < 4) || done2 !== (j == 4)) begin
          n_bad++; $display("FAIL n2 busy/done j=%0d got %b/%b want %b/%b", j, busy2, done2, j < 4, j == 4);
        end
        n_cmp++;
        if (err_count2 !== 3'(e) || first_err_valid2 !== fv || first_err_vec2 !== fvec) begin
          n_bad++; $display("FAIL n2 err j=%0d got %0d/%b/%b want %0d/%b/%b",
                            j, err_count2, first_err_valid2, first_err_vec2, e, fv, fvec);
        end
        if (j == 4) begin
          n_cmp++;
          if (pass2 !== (e == 0)) begin
            n_bad++; $display("FAIL n2 pass got %b want %b", pass2, e == 0);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_two_faults();
    test_all_fail();
    test_start_ignored_and_restart();
    test_reset_midrun();
    test_random();
    test_n2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
